data_memory_bank: RTL and testbench

Parametrised, byte-addressable data memory for the single-cycle/multicycle CPU datapath, succeeding the fixed word-only data memory. It supports byte, halfword and word loads and stores, with sign or zero extension on loads. Reads are synchronous, with a one-cycle latency and a valid strobe. Misaligned, out-of-range and reserved-size accesses raise an error flag, and an optional post-reset clear sweep zeroes the array before the block reports ready.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/data_memory_bank.sv | 130 +++++++++++++
 tb/tb_data_memory_bank.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and size helper for the byte-addressable data memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Reserved size reports 4 so the range check stays conservative.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: store byte enables/write word, and load extraction with extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] din,
  input  logic [31:0] raw,
  input  logic        sgn,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata
);

  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  // be[3] is the lowest address of the word (bits 31:24).
  always_comb begin
    be    = 4'b0000;
    wword = din;
    case (size)
      SZ_BYTE: begin
        be    = 4'b1000 >> off;
        wword = {4{din[7:0]}};
      end
      SZ_HALF: begin
        be    = off[1] ? 4'b0011 : 4'b1100;
        wword = {2{din[15:0]}};
      end
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    lbyte = raw[31:24];
      2'd1:    lbyte = raw[23:16];
      2'd2:    lbyte = raw[15:8];
      default: lbyte = raw[7:0];
    endcase
    lhalf = off[1] ? raw[15:0] : raw[31:16];
    case (size)
      SZ_BYTE: ldata = {{24{sgn & lbyte[7]}}, lbyte};
      SZ_HALF: ldata = {{16{sgn & lhalf[15]}}, lhalf};
      default: ldata = raw;
    endcase
  end

endmodule

// File: rtl/data_memory_bank.sv
// Byte-addressable data memory with 1-cycle synchronous reads, Err pulse on illegal access.
// Optional post-reset zeroing sweep enabled by defining DMEM_INIT_CLEAR_EN.
module data_memory_bank
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_BYTES = 128
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [31:0]       DataIn,
  input  logic              RD,
  input  logic              WR,
  input  logic [1:0]        Size,
  input  logic              Signed,
  output logic              Ready,
  output logic              RValid,
  output logic [31:0]       DataOut,
  output logic              Err
);

  localparam int AW     = $clog2(DEPTH_BYTES);
  localparam int WW     = (AW > 2) ? AW - 2 : 1;
  localparam int NWORDS = DEPTH_BYTES / 4;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_BYTES);

  logic [7:0]        mem [DEPTH_BYTES];
  logic [WW-1:0]     wi;
  logic [31:0]       raw, wword, ldata, dout_q;
  logic [3:0]        be;
  logic [ADDR_W:0]   last;
  logic              aligned, legal, acc, ready, clr_we;
  logic [WW-1:0]     cnt;

  assign wi   = WW'(DAddr[AW-1:0] >> 2);
  assign raw  = {mem[{wi, 2'd0}], mem[{wi, 2'd1}], mem[{wi, 2'd2}], mem[{wi, 2'd3}]};
  assign last = {1'b0, DAddr} + (ADDR_W + 1)'(size_bytes(Size)) - 1'b1;

  assign aligned = (Size == SZ_BYTE) ||
                   (Size == SZ_HALF && !DAddr[0]) ||
                   (Size == SZ_WORD && DAddr[1:0] == 2'b00);
  assign legal   = (Size != SZ_RSVD) && aligned && (last < DEPTH_L);
  assign acc     = RST && ready && (!RD || !WR);

  dmem_lane_align u_align (
    .size  (Size),
    .off   (DAddr[1:0]),
    .din   (DataIn),
    .raw   (raw),
    .sgn   (Signed),
    .be    (be),
    .wword (wword),
    .ldata (ldata)
  );

`ifdef DMEM_INIT_CLEAR_EN
  // state | meaning
  // INIT  | clearing word cnt each cycle, Ready = 0
  // RUN   | servicing requests, Ready = 1
  state_t        state, state_nx;
  logic [WW-1:0] cnt_nx;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    clr_we   = 1'b0;
    ready    = 1'b0;
    case (state)
      INIT: begin
        clr_we = 1'b1;
        cnt_nx = cnt + 1'b1;
        if (cnt == WW'(NWORDS - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
      RUN:     ready = 1'b1;
      default: state_nx = INIT;
    endcase
  end
`else
  logic ready_q;

  always_ff @(posedge CLK) begin
    if (!RST) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  assign ready  = ready_q;
  assign clr_we = 1'b0;
  assign cnt    = '0;
`endif

  // Array has no reset; NBA ordering gives read-before-write on combined requests.
  always_ff @(posedge CLK) begin
    if (RST && clr_we) begin
      for (int i = 0; i < 4; i++) mem[{cnt, 2'(i)}] <= 8'h00;
    end else if (acc && legal && !WR) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[{wi, 2'(3 - i)}] <= wword[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      RValid <= 1'b0;
      Err    <= 1'b0;
      dout_q <= '0;
    end else begin
      RValid <= acc && legal && !RD;
      Err    <= acc && !legal;
      if (acc && legal && !RD) dout_q <= ldata;
    end
  end

  assign Ready   = ready;
  assign DataOut = RValid ? dout_q : 32'bz;

endmodule

// File: tb/tb_data_memory_bank.sv
// Directed self-checking bench for data_memory_bank (default parameters).
module tb_data_memory_bank;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] DAddr = '0;
  logic [31:0] DataIn = '0;
  logic        RD = 1'b1;
  logic        WR = 1'b1;
  logic [1:0]  Size = 2'b10;
  logic        Signed = 1'b0;
  logic        Ready, RValid, Err;
  wire  [31:0] DataOut;

  int checks = 0;
  int failures = 0;

  data_memory_bank #(.ADDR_W(32), .DEPTH_BYTES(128)) dut (
    .CLK(CLK), .RST(RST), .DAddr(DAddr), .DataIn(DataIn), .RD(RD), .WR(WR),
    .Size(Size), .Signed(Signed), .Ready(Ready), .RValid(RValid),
    .DataOut(DataOut), .Err(Err)
  );

  always #5 CLK = ~CLK;

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz,
                    input logic sg, input logic [31:0] a, input logic [31:0] d);
    RD = rd; WR = wr; Size = sz; Signed = sg; DAddr = a; DataIn = d;
    @(posedge CLK); #1;
    RD = 1'b1; WR = 1'b1;
  endtask

  task automatic wait_ready(input int expected);
    int n = 0;
    while (!Ready && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n !== expected) begin
      failures++;
      $display("FAIL ready_edge: got %0d expected %0d", n, expected);
    end
  endtask

  task automatic test_reset();
    RST = 1'b0; RD = 1'b1; WR = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++;
    if (Ready !== 1'b0 || RValid !== 1'b0 || Err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got R=%b V=%b E=%b expected 0 0 0", Ready, RValid, Err);
    end
    RST = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
    wait_ready(32);
`else
    wait_ready(1);
`endif
  endtask

  task automatic test_word();
    op(1, 0, 2'b10, 0, 32'd8, 32'h12345678);
    op(0, 1, 2'b10, 0, 32'd8, 32'h0);
    checks++;
    if (RValid !== 1'b1 || DataOut !== 32'h12345678) begin
      failures++;
      $display("FAIL word_load: got V=%b %h expected 1 12345678", RValid, DataOut);
    end
    op(0, 1, 2'b00, 0, 32'd9, 32'h0);
    checks++;
    if (DataOut !== 32'h00000034) begin
      failures++;
      $display("FAIL byte_load_9: got %h expected 00000034", DataOut);
    end
    @(posedge CLK); #1;
    checks++;
    if (RValid !== 1'b0) begin
      failures++;
      $display("FAIL rvalid_idle: got %b expected 0", RValid);
    end
  endtask

  task automatic test_byte();
    op(1, 0, 2'b10, 0, 32'd12, 32'h0);
    op(1, 0, 2'b00, 0, 32'd14, 32'hFFFFFF80);
    op(0, 1, 2'b10, 0, 32'd12, 32'h0);
    checks++;
    if (DataOut !== 32'h00008000) begin
      failures++;
      $display("FAIL byte_store_word: got %h expected 00008000", DataOut);
    end
    op(0, 1, 2'b00, 1, 32'd14, 32'h0);
    checks++;
    if (DataOut !== 32'hFFFFFF80) begin
      failures++;
      $display("FAIL byte_signed: got %h expected ffffff80", DataOut);
    end
    op(0, 1, 2'b00, 0, 32'd14, 32'h0);
    checks++;
    if (DataOut !== 32'h00000080) begin
      failures++;
      $display("FAIL byte_unsigned: got %h expected 00000080", DataOut);
    end
  endtask

  task automatic test_half();
    op(1, 0, 2'b10, 0, 32'd16, 32'h0);
    op(1, 0, 2'b01, 0, 32'd16, 32'h1234BEEF);
    op(0, 1, 2'b10, 0, 32'd16, 32'h0);
    checks++;
    if (DataOut !== 32'hBEEF0000) begin
      failures++;
      $display("FAIL half_store_word: got %h expected beef0000", DataOut);
    end
    op(0, 1, 2'b01, 1, 32'd16, 32'h0);
    checks++;
    if (DataOut !== 32'hFFFFBEEF) begin
      failures++;
      $display("FAIL half_signed: got %h expected ffffbeef", DataOut);
    end
    op(0, 1, 2'b01, 0, 32'd16, 32'h0);
    checks++;
    if (DataOut !== 32'h0000BEEF) begin
      failures++;
      $display("FAIL half_unsigned: got %h expected 0000beef", DataOut);
    end
  endtask

  task automatic test_errors();
    op(1, 0, 2'b10, 0, 32'd0, 32'h11223344);
    op(1, 0, 2'b10, 0, 32'd4, 32'h55667788);
    op(0, 1, 2'b10, 0, 32'd6, 32'h0);
    checks++;
    if (Err !== 1'b1 || RValid !== 1'b0) begin
      failures++;
      $display("FAIL err_word_misalign: got E=%b V=%b expected 1 0", Err, RValid);
    end
    @(posedge CLK); #1;
    checks++;
    if (Err !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse_width: got %b expected 0", Err);
    end
    op(1, 0, 2'b01, 0, 32'd3, 32'h0000AAAA);
    checks++;
    if (Err !== 1'b1) begin
      failures++;
      $display("FAIL err_half_misalign: got %b expected 1", Err);
    end
    op(0, 1, 2'b11, 0, 32'd0, 32'h0);
    checks++;
    if (Err !== 1'b1 || RValid !== 1'b0) begin
      failures++;
      $display("FAIL err_rsvd_size: got E=%b V=%b expected 1 0", Err, RValid);
    end
    op(1, 0, 2'b10, 0, 32'd128, 32'hDEADBEEF);
    checks++;
    if (Err !== 1'b1) begin
      failures++;
      $display("FAIL err_range: got %b expected 1", Err);
    end
    op(0, 1, 2'b10, 0, 32'd0, 32'h0);
    checks++;
    if (Err !== 1'b0 || DataOut !== 32'h11223344) begin
      failures++;
      $display("FAIL err_unchanged_0: got E=%b %h expected 0 11223344", Err, DataOut);
    end
    op(0, 1, 2'b10, 0, 32'd4, 32'h0);
    checks++;
    if (DataOut !== 32'h55667788) begin
      failures++;
      $display("FAIL err_unchanged_4: got %h expected 55667788", DataOut);
    end
  endtask

  task automatic test_simultaneous();
    op(1, 0, 2'b10, 0, 32'd20, 32'hAAAAAAAA);
    op(0, 0, 2'b10, 0, 32'd20, 32'h55555555);
    checks++;
    if (RValid !== 1'b1 || DataOut !== 32'hAAAAAAAA) begin
      failures++;
      $display("FAIL rw_old_data: got V=%b %h expected 1 aaaaaaaa", RValid, DataOut);
    end
    op(0, 1, 2'b10, 0, 32'd20, 32'h0);
    checks++;
    if (DataOut !== 32'h55555555) begin
      failures++;
      $display("FAIL rw_new_data: got %h expected 55555555", DataOut);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    exp[0] = 32'h01020304; exp[1] = 32'hA0B0C0D0; exp[2] = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) op(1, 0, 2'b10, 0, 32'd32 + 32'(4 * i), exp[i]);
    RD = 1'b0; WR = 1'b1; Size = 2'b10; Signed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      DAddr = 32'd32 + 32'(4 * i);
      @(posedge CLK); #1;
      checks++;
      if (RValid !== 1'b1 || DataOut !== exp[i]) begin
        failures++;
        $display("FAIL b2b_read_%0d: got V=%b %h expected 1 %h", i, RValid, DataOut, exp[i]);
      end
    end
    RD = 1'b1;
  endtask

`ifdef DMEM_INIT_CLEAR_EN
  task automatic test_reset_clear();
    int bad = 0;
    op(1, 0, 2'b10, 0, 32'd24, 32'hDEADBEEF);
    RD = 1'b0; Size = 2'b10; DAddr = 32'd24; RST = 1'b0;
    @(posedge CLK); #1;
    RD = 1'b1;
    checks++;
    if (RValid !== 1'b0 || Err !== 1'b0 || Ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_midread: got V=%b E=%b R=%b expected 0 0 0", RValid, Err, Ready);
    end
    RST = 1'b1;
    wait_ready(32);
    for (int w = 0; w < 32; w++) begin
      op(0, 1, 2'b10, 0, 32'(4 * w), 32'h0);
      if (DataOut !== 32'h0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL clear_sweep: got %0d nonzero words expected 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_simultaneous();
    test_back_to_back();
`ifdef DMEM_INIT_CLEAR_EN
    test_reset_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
